// File: rtl/daq_page_ring.sv
// Page-ring buffer manager: frames an event stream into fixed-size RAM pages and tracks per-page lengths.
// Optional DAQ_PAGE_RING_STATS_EN adds evt_count / hwm_occ statistics outputs.
module daq_page_ring #(
  parameter int DATA_W          = 32,
  parameter int LOG2_NPAGES     = 6,
  parameter int LOG2_PAGE_WORDS = 9,
  parameter int MEM_AW          = LOG2_NPAGES + LOG2_PAGE_WORDS,
  parameter int LEN_W           = LOG2_PAGE_WORDS + 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [1:0]             cfg_page_mode,
  input  logic [LOG2_NPAGES-1:0] cfg_busy_on,
  input  logic [LOG2_NPAGES-1:0] cfg_busy_off,
  input  logic                   wr_valid,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_last,
  output logic                   mem_we,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   rd_avail,
  output logic [LOG2_NPAGES-1:0] rd_page,
  output logic [LEN_W:0]         rd_len,
  input  logic                   rd_release,
  output logic [LOG2_NPAGES:0]   occupancy,
  output logic                   full,
  output logic                   empty,
  output logic                   busy,
  output logic [15:0]            drop_count,
  output logic [1:0]             mode_active
`ifdef DAQ_PAGE_RING_STATS_EN
  ,
  output logic [31:0]            evt_count,
  output logic [LOG2_NPAGES:0]   hwm_occ
`endif
);

  localparam int NPAGES = 1 << LOG2_NPAGES;

  typedef enum logic [1:0] {IDLE, ACCEPT, DROP} state_t;

  state_t                 state, state_nxt;
  logic [LOG2_NPAGES-1:0] w_page, r_page, pmask;
  logic [LOG2_NPAGES:0]   occ, occ_nxt;
  logic [LEN_W-1:0]       cnt, cap, len_new;
  logic                   ovf, ovf_new;
  logic [LEN_W:0]         len_tab [NPAGES];
  logic [1:0]             cfg_mode;
  logic                   take, drop_word, room, wr_fire, commit, rel, latch;
  logic [MEM_AW-1:0]      addr_c;

  always_comb begin
    cfg_mode  = (cfg_page_mode == 2'd3) ? 2'd2 : cfg_page_mode;
    pmask     = {LOG2_NPAGES{1'b1}} >> mode_active;
    cap       = {{(LEN_W-1){1'b0}}, 1'b1} << (LOG2_PAGE_WORDS + mode_active);
    full      = (occ == {1'b0, pmask});
    empty     = (occ == '0);
    rd_avail  = !empty;
    take      = wr_valid && ((state == IDLE && !full) || state == ACCEPT);
    drop_word = wr_valid && ((state == IDLE && full) || state == DROP);
    room      = (cnt < cap);
    wr_fire   = take && room;
    commit    = take && wr_last;
    rel       = rd_release && !empty;
    occ_nxt   = occ + {{LOG2_NPAGES{1'b0}}, commit} - {{LOG2_NPAGES{1'b0}}, rel};
    len_new   = room ? cnt + 1'b1 : cnt;
    ovf_new   = ovf | !room;
    // Mode only changes on a quiet, empty ring so no page straddles two geometries
    latch     = empty && state == IDLE && !wr_valid && (cfg_mode != mode_active);
    addr_c    = (MEM_AW'(w_page & pmask) << (LOG2_PAGE_WORDS + mode_active)) | MEM_AW'(cnt);
    occupancy = occ;
    rd_page   = r_page;
    rd_len    = empty ? '0 : len_tab[r_page];
  end

  // Accept/drop is decided on the first word; single-word events never leave IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_valid && !wr_last) state_nxt = full ? DROP : ACCEPT;
      ACCEPT,
      DROP:    if (wr_valid && wr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      w_page      <= '0;
      r_page      <= '0;
      occ         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      drop_count  <= '0;
      mode_active <= 2'd0;
    end else if (clear) begin
      state       <= IDLE;
      w_page      <= '0;
      r_page      <= '0;
      occ         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      drop_count  <= '0;
      mode_active <= cfg_mode;
    end else begin
      state  <= state_nxt;
      mem_we <= wr_fire;
      if (wr_fire) begin
        mem_addr  <= addr_c;
        mem_wdata <= wr_data;
      end
      if (commit) begin
        cnt    <= '0;
        ovf    <= 1'b0;
        w_page <= (w_page + 1'b1) & pmask;
      end else if (take) begin
        cnt <= len_new;
        ovf <= ovf_new;
      end
      if (rel) r_page <= (r_page + 1'b1) & pmask;
      occ <= occ_nxt;
      if (drop_word && wr_last && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      // Release threshold takes priority over assert threshold
      if (occ_nxt == '0 || occ_nxt <= {1'b0, cfg_busy_off}) busy <= 1'b0;
      else if (occ_nxt >= {1'b0, cfg_busy_on})             busy <= 1'b1;
      if (latch) begin
        mode_active <= cfg_mode;
        w_page      <= '0;
        r_page      <= '0;
      end
    end
  end

  // Length table needs no reset: rd_len is masked while the ring is empty
  always_ff @(posedge clk) begin
    if (reset_n && !clear && commit) len_tab[w_page] <= {ovf_new, len_new};
  end

`ifdef DAQ_PAGE_RING_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_count <= '0;
      hwm_occ   <= '0;
    end else if (clear) begin
      evt_count <= '0;
      hwm_occ   <= '0;
    end else begin
      if (commit) evt_count <= evt_count + 32'd1;
      if (occ_nxt > hwm_occ) hwm_occ <= occ_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_daq_page_ring.sv
// Directed bench for daq_page_ring: framing, full/drop, overflow, busy hysteresis, mode switch, reset.
module tb_daq_page_ring;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  cfg_page_mode = 2'd0;
  logic [5:0]  cfg_busy_on = 6'd63;
  logic [5:0]  cfg_busy_off = 6'd0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_last = 1'b0;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        rd_avail;
  logic [5:0]  rd_page;
  logic [12:0] rd_len;
  logic        rd_release = 1'b0;
  logic [6:0]  occupancy;
  logic        full, empty, busy;
  logic [15:0] drop_count;
  logic [1:0]  mode_active;

  int checks = 0;
  int errors = 0;

  daq_page_ring dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .cfg_page_mode(cfg_page_mode),
    .cfg_busy_on(cfg_busy_on), .cfg_busy_off(cfg_busy_off), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_last(wr_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .rd_avail(rd_avail), .rd_page(rd_page), .rd_len(rd_len),
    .rd_release(rd_release), .occupancy(occupancy), .full(full), .empty(empty),
    .busy(busy), .drop_count(drop_count), .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_valid = 0; wr_last = 0; rd_release = 0; clear = 0;
    reset_n = 0;
    repeat (2) tick();
    reset_n = 1;
    tick();
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    wr_valid = 1; wr_data = d; wr_last = last;
    tick();
  endtask

  task automatic release_one();
    rd_release = 1;
    tick();
    rd_release = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0h exp 0", mem_we); end
    checks++; if (occupancy !== 7'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if ({empty, full, rd_avail, busy} !== 4'b1000) begin errors++; $display("FAIL reset_flags got %b exp 1000", {empty, full, rd_avail, busy}); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
    checks++; if (rd_len !== 13'd0) begin errors++; $display("FAIL reset_rd_len got %0h exp 0", rd_len); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_word(32'hA0 + i, i == 2);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 15'(i) || mem_wdata !== 32'hA0 + i) begin
        errors++; $display("FAIL basic_write%0d got we=%0b addr=%0h data=%0h exp we=1 addr=%0h data=%0h", i, mem_we, mem_addr, mem_wdata, i, 32'hA0 + i);
      end
    end
    wr_valid = 0; wr_last = 0;
    checks++; if (occupancy !== 7'd1 || rd_avail !== 1'b1) begin errors++; $display("FAIL basic_occ got occ=%0d avail=%0b exp occ=1 avail=1", occupancy, rd_avail); end
    tick();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL basic_we_idle got %0b exp 0", mem_we); end
    checks++; if (rd_len !== 13'd3 || rd_page !== 6'd0) begin errors++; $display("FAIL basic_rd_len got len=%0h page=%0d exp len=3 page=0", rd_len, rd_page); end
  endtask

  task automatic test_full_drop();
    int we_seen;
    cfg_page_mode = 2'd3;
    clear = 1; tick(); clear = 0;
    checks++; if (mode_active !== 2'd2) begin errors++; $display("FAIL drop_mode got %0d exp 2", mode_active); end
    for (int e = 0; e < 15; e++) begin
      send_word(32'h100 + e, 1'b0);
      if (e == 14) begin
        checks++; if (mem_addr !== 15'h7000) begin errors++; $display("FAIL drop_page14_addr got %0h exp 7000", mem_addr); end
      end
      send_word(32'h200 + e, 1'b1);
    end
    wr_valid = 0; wr_last = 0;
    checks++; if (full !== 1'b1 || occupancy !== 7'd15) begin errors++; $display("FAIL drop_full got full=%0b occ=%0d exp full=1 occ=15", full, occupancy); end
    we_seen = 0;
    send_word(32'hDEAD, 1'b0); we_seen += int'(mem_we);
    send_word(32'hBEEF, 1'b1); we_seen += int'(mem_we);
    wr_valid = 0; wr_last = 0;
    checks++; if (we_seen !== 0) begin errors++; $display("FAIL drop_no_write got %0d writes exp 0", we_seen); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_count got %0d exp 1", drop_count); end
    release_one();
    checks++; if (full !== 1'b0 || rd_page !== 6'd1) begin errors++; $display("FAIL drop_release got full=%0b page=%0d exp full=0 page=1", full, rd_page); end
    send_word(32'h300, 1'b0);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 15'h7800) begin errors++; $display("FAIL drop_page15_addr got we=%0b addr=%0h exp we=1 addr=7800", mem_we, mem_addr); end
    send_word(32'h301, 1'b0);
  endtask

  task automatic test_async_reset();
    // Event left open by the previous scenario; reset lands between clock edges
    #2 reset_n = 0;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 15'd0) begin errors++; $display("FAIL areset_mem got we=%0b addr=%0h exp 0 0", mem_we, mem_addr); end
    checks++; if (occupancy !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL areset_ring got occ=%0d empty=%0b full=%0b exp 0 1 0", occupancy, empty, full); end
    checks++; if (drop_count !== 16'd0 || mode_active !== 2'd0) begin errors++; $display("FAIL areset_drop got drop=%0d mode=%0d exp 0 0", drop_count, mode_active); end
    wr_valid = 0; wr_last = 0; cfg_page_mode = 2'd0;
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_overflow();
    int we_seen;
    do_reset();
    we_seen = 0;
    for (int i = 0; i < 600; i++) begin
      send_word(32'(i), i == 599);
      we_seen += int'(mem_we);
    end
    wr_valid = 0; wr_last = 0;
    tick();
    we_seen += int'(mem_we);
    checks++; if (we_seen !== 512) begin errors++; $display("FAIL ovf_writes got %0d exp 512", we_seen); end
    checks++; if (rd_len !== 13'h1200) begin errors++; $display("FAIL ovf_rd_len got %0h exp 1200", rd_len); end
    checks++; if (mem_addr !== 15'h1FF) begin errors++; $display("FAIL ovf_last_addr got %0h exp 1ff", mem_addr); end
  endtask

  task automatic test_busy();
    do_reset();
    cfg_busy_on = 6'd4; cfg_busy_off = 6'd2;
    for (int e = 0; e < 4; e++) begin
      send_word(32'h40 + e, 1'b1);
      if (e == 2) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_occ3_rise got %0b exp 0", busy); end
      end
    end
    wr_valid = 0; wr_last = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_occ4 got %0b exp 1", busy); end
    release_one();
    checks++; if (busy !== 1'b1 || occupancy !== 7'd3) begin errors++; $display("FAIL busy_occ3_hold got busy=%0b occ=%0d exp 1 3", busy, occupancy); end
    release_one();
    checks++; if (busy !== 1'b0 || occupancy !== 7'd2) begin errors++; $display("FAIL busy_occ2 got busy=%0b occ=%0d exp 0 2", busy, occupancy); end
    cfg_busy_on = 6'd63; cfg_busy_off = 6'd0;
  endtask

  task automatic test_mode_switch();
    do_reset();
    send_word(32'h55, 1'b1);
    wr_valid = 0; wr_last = 0;
    cfg_page_mode = 2'd1;
    tick(); tick();
    checks++; if (mode_active !== 2'd0) begin errors++; $display("FAIL mode_pending got %0d exp 0", mode_active); end
    release_one();
    tick();
    checks++; if (mode_active !== 2'd1) begin errors++; $display("FAIL mode_latched got %0d exp 1", mode_active); end
    send_word(32'h60, 1'b0);
    checks++; if (mem_addr !== 15'h0000) begin errors++; $display("FAIL mode_ev1_addr got %0h exp 0", mem_addr); end
    send_word(32'h61, 1'b1);
    send_word(32'h70, 1'b1);
    wr_valid = 0; wr_last = 0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 15'h0400) begin errors++; $display("FAIL mode_ev2_addr got we=%0b addr=%0h exp 1 400", mem_we, mem_addr); end
    cfg_page_mode = 2'd0;
  endtask

  task automatic test_commit_release();
    do_reset();
    send_word(32'h11, 1'b1);
    rd_release = 1;
    send_word(32'h22, 1'b1);
    rd_release = 0; wr_valid = 0; wr_last = 0;
    checks++; if (occupancy !== 7'd1) begin errors++; $display("FAIL cr_occ got %0d exp 1", occupancy); end
    checks++; if (rd_page !== 6'd1 || rd_len !== 13'd1) begin errors++; $display("FAIL cr_rd got page=%0d len=%0h exp 1 1", rd_page, rd_len); end
    release_one();
    release_one();
    checks++; if (occupancy !== 7'd0 || rd_page !== 6'd2) begin errors++; $display("FAIL cr_empty_release got occ=%0d page=%0d exp 0 2", occupancy, rd_page); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_drop();
    test_async_reset();
    test_overflow();
    test_busy();
    test_mode_switch();
    test_commit_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
